// File: rtl/hex_sr_pkg.sv
// Shared constants for the hex shift-register host.
// State codes, opcodes and small state-class helpers.
package hex_sr_pkg;

  localparam int DATA_W = 6;

  localparam logic OP_WRITE = 1'b0;
  localparam logic OP_READ  = 1'b1;

  typedef logic [2:0] state_t;

  localparam state_t S_IDLE    = 3'd0;
  localparam state_t S_W_FETCH = 3'd1;
  localparam state_t S_W_LOW   = 3'd2;
  localparam state_t S_W_HIGH  = 3'd3;
  localparam state_t S_R_LOW   = 3'd4;
  localparam state_t S_R_PUSH  = 3'd5;
  localparam state_t S_R_HIGH  = 3'd6;

  function automatic logic is_write(input state_t s);
    return (s == S_W_FETCH) || (s == S_W_LOW) || (s == S_W_HIGH);
  endfunction

  function automatic logic is_high(input state_t s);
    return (s == S_W_HIGH) || (s == S_R_HIGH);
  endfunction

endpackage

// File: rtl/hex_sr_phase_timer.sv
// Half-period down-counter for the derived SR clock.
// load restarts a HALF-cycle phase; expire marks its last cycle.
module hex_sr_phase_timer
  import hex_sr_pkg::*;
#(
  parameter int HALF = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic load,
  output logic expire
);

  localparam int TW = $clog2(HALF);

  logic [TW-1:0] tmr;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tmr <= '0;
    end else if (load) begin
      tmr <= TW'(HALF - 1);
    end else if (tmr != '0) begin
      tmr <= tmr - TW'(1);
    end
  end

  assign expire = (tmr == '0);

endmodule

// File: rtl/hex_sr_host.sv
// Host controller for the off-chip hex recirculating shift register.
// Writes/reads one LENGTH-word frame per command over valid/ready streams.
module hex_sr_host
  import hex_sr_pkg::*;
#(
  parameter int LENGTH = 400,
  parameter int HALF   = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cmd_valid,
  input  logic              cmd_op,
  output logic              cmd_ready,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              wr_valid,
  output logic              wr_ready,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_valid,
  input  logic              rd_ready,
  output logic              busy,
  output logic              sr_clk,
  output logic              sr_recirc,
  output logic [DATA_W-1:0] sr_data,
  input  logic [DATA_W-1:0] sr_q
);

  localparam int CW = $clog2(LENGTH);
  localparam logic [CW-1:0] LAST = CW'(LENGTH - 1);

  state_t state;
  state_t state_d;

  logic [CW-1:0]     cnt;
  logic [DATA_W-1:0] sr_q_r;

  logic load;
  logic expire;
  logic cnt_clr;
  logic cnt_inc;
  logic take_wr;
  logic take_rd;

  hex_sr_phase_timer #(
    .HALF (HALF)
  ) u_timer (
    .clk    (clk),
    .rst    (rst),
    .load   (load),
    .expire (expire)
  );

  always_comb begin
    state_d = state;
    load    = 1'b0;
    cnt_clr = 1'b0;
    cnt_inc = 1'b0;
    take_wr = 1'b0;
    take_rd = 1'b0;
    unique case (state)
      S_IDLE: begin
        if (cmd_valid) begin
          cnt_clr = 1'b1;
          if (cmd_op == OP_READ) begin
            state_d = S_R_LOW;
            load    = 1'b1;
          end else begin
            state_d = S_W_FETCH;
          end
        end
      end
      S_W_FETCH: begin
        if (wr_valid) begin
          take_wr = 1'b1;
          state_d = S_W_LOW;
          load    = 1'b1;
        end
      end
      S_W_LOW: begin
        if (expire) begin
          state_d = S_W_HIGH;
          load    = 1'b1;
        end
      end
      S_W_HIGH: begin
        if (expire) begin
          if (cnt == LAST) begin
            state_d = S_IDLE;
          end else begin
            cnt_inc = 1'b1;
            state_d = S_W_FETCH;
          end
        end
      end
      S_R_LOW: begin
        if (expire) begin
          take_rd = 1'b1;
          state_d = S_R_PUSH;
        end
      end
      S_R_PUSH: begin
        // Holding here keeps the SR clock low, so backpressure never loses a word
        if (rd_ready) begin
          state_d = S_R_HIGH;
          load    = 1'b1;
        end
      end
      S_R_HIGH: begin
        if (expire) begin
          if (cnt == LAST) begin
            state_d = S_IDLE;
          end else begin
            cnt_inc = 1'b1;
            state_d = S_R_LOW;
            load    = 1'b1;
          end
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= S_IDLE;
      cnt       <= '0;
      sr_q_r    <= '0;
      sr_clk    <= 1'b0;
      sr_recirc <= 1'b1;
      sr_data   <= '0;
      rd_data   <= '0;
      rd_valid  <= 1'b0;
      wr_ready  <= 1'b0;
      busy      <= 1'b0;
      cmd_ready <= 1'b1;
    end else begin
      state     <= state_d;
      sr_q_r    <= sr_q;
      // Pin-facing outputs are registered from the next state
      sr_clk    <= is_high(state_d);
      sr_recirc <= !is_write(state_d);
      rd_valid  <= (state_d == S_R_PUSH);
      wr_ready  <= (state_d == S_W_FETCH);
      busy      <= (state_d != S_IDLE);
      cmd_ready <= (state_d == S_IDLE);
      if (cnt_clr) begin
        cnt <= '0;
      end else if (cnt_inc) begin
        cnt <= cnt + CW'(1);
      end
      if (take_wr) begin
        sr_data <= wr_data;
      end
      if (take_rd) begin
        rd_data <= sr_q_r;
      end
    end
  end

endmodule

// File: tb/tb_hex_sr_host.sv
// Bench for hex_sr_host against a behavioural 6-lane recirc SR.
// Read words are checked against a queue of expected frame words.
`timescale 1ns/1ps
module tb_hex_sr_host;

  localparam int L = 4;
  localparam int H = 2;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       cmd_valid = 1'b0;
  logic       cmd_op = 1'b0;
  logic       cmd_ready;
  logic [5:0] wr_data = 6'd0;
  logic       wr_valid = 1'b0;
  logic       wr_ready;
  logic [5:0] rd_data;
  logic       rd_valid;
  logic       rd_ready = 1'b0;
  logic       busy;
  logic       sr_clk;
  logic       sr_recirc;
  logic [5:0] sr_data;
  logic [5:0] sr_q;

  logic [5:0] mem [L];
  logic [5:0] frame [L];
  logic [5:0] exp_q [$];

  int vecs = 0;
  int errs = 0;
  int rises = 0;
  int rd_got = 0;
  int stab = 0;
  int hi_run = 0;
  int lo_run = 0;
  logic prev_clk = 1'b0;
  logic [5:0] prev_data = 6'd0;
  logic [5:0] rise_data = 6'd0;
  logic exp_recirc = 1'b1;

  hex_sr_host #(
    .LENGTH (L),
    .HALF   (H)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .cmd_valid (cmd_valid),
    .cmd_op    (cmd_op),
    .cmd_ready (cmd_ready),
    .wr_data   (wr_data),
    .wr_valid  (wr_valid),
    .wr_ready  (wr_ready),
    .rd_data   (rd_data),
    .rd_valid  (rd_valid),
    .rd_ready  (rd_ready),
    .busy      (busy),
    .sr_clk    (sr_clk),
    .sr_recirc (sr_recirc),
    .sr_data   (sr_data),
    .sr_q      (sr_q)
  );

  always #5 clk = ~clk;

  assign sr_q = mem[L-1];

  // Off-chip SR: each lane shifts on sr_clk rise, head fed by tail or data_in
  always @(posedge sr_clk) begin
    for (int i = L - 1; i > 0; i--) mem[i] <= mem[i-1];
    mem[0] <= sr_recirc ? mem[L-1] : sr_data;
  end

  always @(posedge sr_clk) begin
    if (!rst) begin
      rises++;
      rise_data = sr_data;
      vecs++;
      if (sr_recirc !== exp_recirc) begin
        errs++;
        $display("FAIL recirc_at_rise got %b want %b", sr_recirc, exp_recirc);
      end
      vecs++;
      if (stab < H) begin
        errs++;
        $display("FAIL data_setup got %0d cycles want >=%0d", stab, H);
      end
    end
  end

  always @(negedge clk) begin
    if (sr_data == prev_data) stab++;
    else stab = 1;
    prev_data = sr_data;
    if (rst) begin
      hi_run = 0;
      lo_run = 0;
      prev_clk = 1'b0;
    end else begin
      if (sr_clk) begin
        if (prev_clk) begin
          hi_run++;
        end else begin
          vecs++;
          if (lo_run < H) begin
            errs++;
            $display("FAIL low_phase got %0d want >=%0d", lo_run, H);
          end
          hi_run = 1;
        end
        if (sr_data !== rise_data) begin
          vecs++;
          errs++;
          $display("FAIL data_hold got %h want %h", sr_data, rise_data);
        end
      end else begin
        if (!prev_clk) begin
          lo_run++;
        end else begin
          vecs++;
          if (hi_run != H) begin
            errs++;
            $display("FAIL high_phase got %0d want %0d", hi_run, H);
          end
          lo_run = 1;
        end
      end
      prev_clk = sr_clk;
      if (rd_valid && rd_ready) begin
        vecs++;
        if (exp_q.size() == 0) begin
          errs++;
          $display("FAIL rd_unexpected got %h want none", rd_data);
        end else begin
          logic [5:0] e;
          e = exp_q.pop_front();
          if (rd_data !== e) begin
            errs++;
            $display("FAIL rd_word got %h want %h", rd_data, e);
          end
        end
        rd_got++;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic op);
    int n = 0;
    while (!cmd_ready && n < 200) begin
      tick();
      n++;
    end
    vecs++;
    if (cmd_ready !== 1'b1) begin
      errs++;
      $display("FAIL cmd_ready_wait got %b want 1", cmd_ready);
    end
    cmd_op = op;
    cmd_valid = 1'b1;
    tick();
    cmd_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    while (busy && n < 500) begin
      tick();
      n++;
    end
    vecs++;
    if (busy !== 1'b0) begin
      errs++;
      $display("FAIL idle_wait got busy=%b want 0", busy);
    end
  endtask

  task automatic wait_wr_ready();
    int n = 0;
    while (!wr_ready && n < 200) begin
      tick();
      n++;
    end
    vecs++;
    if (wr_ready !== 1'b1) begin
      errs++;
      $display("FAIL wr_ready_wait got %b want 1", wr_ready);
    end
  endtask

  task automatic write_frame(input int stall);
    int r0;
    int r1;
    r0 = rises;
    exp_recirc = 1'b0;
    issue(1'b0);
    for (int k = 0; k < L; k++) begin
      wait_wr_ready();
      if (k == stall) begin
        r1 = rises;
        repeat (10) begin
          tick();
          vecs++;
          if (sr_clk !== 1'b0 || wr_ready !== 1'b1) begin
            errs++;
            $display("FAIL wr_stall got clk=%b rdy=%b want 0/1", sr_clk, wr_ready);
          end
        end
        vecs++;
        if (rises != r1) begin
          errs++;
          $display("FAIL wr_stall_edges got %0d want 0", rises - r1);
        end
      end
      wr_data = frame[k];
      wr_valid = 1'b1;
      tick();
      wr_valid = 1'b0;
    end
    wait_idle();
    vecs++;
    if (rises - r0 != L) begin
      errs++;
      $display("FAIL write_rises got %0d want %0d", rises - r0, L);
    end
    exp_recirc = 1'b1;
  endtask

  task automatic read_frame(input int stall);
    int r0;
    int g0;
    int r1;
    int n;
    r0 = rises;
    g0 = rd_got;
    exp_recirc = 1'b1;
    for (int i = 0; i < L; i++) exp_q.push_back(frame[i]);
    rd_ready = 1'b1;
    issue(1'b1);
    if (stall >= 0) begin
      n = 0;
      while (rd_got - g0 < stall && n < 500) begin
        tick();
        n++;
      end
      rd_ready = 1'b0;
      n = 0;
      while (!rd_valid && n < 200) begin
        tick();
        n++;
      end
      vecs++;
      if (rd_valid !== 1'b1) begin
        errs++;
        $display("FAIL rd_valid_wait got %b want 1", rd_valid);
      end
      r1 = rises;
      repeat (10) begin
        tick();
        vecs++;
        if (sr_clk !== 1'b0 || rd_valid !== 1'b1) begin
          errs++;
          $display("FAIL rd_stall got clk=%b vld=%b want 0/1", sr_clk, rd_valid);
        end
      end
      vecs++;
      if (rises != r1) begin
        errs++;
        $display("FAIL rd_stall_edges got %0d want 0", rises - r1);
      end
      rd_ready = 1'b1;
    end
    wait_idle();
    rd_ready = 1'b0;
    vecs++;
    if (rd_got - g0 != L) begin
      errs++;
      $display("FAIL read_count got %0d want %0d", rd_got - g0, L);
    end
    vecs++;
    if (rises - r0 != L) begin
      errs++;
      $display("FAIL read_rises got %0d want %0d", rises - r0, L);
    end
    vecs++;
    if (exp_q.size() != 0) begin
      errs++;
      $display("FAIL read_leftover got %0d want 0", exp_q.size());
      exp_q.delete();
    end
    for (int i = 0; i < L; i++) begin
      vecs++;
      if (mem[L-1-i] !== frame[i]) begin
        errs++;
        $display("FAIL sr_contents[%0d] got %h want %h", i, mem[L-1-i], frame[i]);
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b0;
    tick();
    tick();
    #3;
    rst = 1'b1;
    #1;
    vecs++;
    if (sr_clk !== 1'b0 || sr_recirc !== 1'b1 || sr_data !== 6'd0) begin
      errs++;
      $display("FAIL reset_sr got %b/%b/%h want 0/1/00", sr_clk, sr_recirc, sr_data);
    end
    vecs++;
    if (rd_data !== 6'd0 || rd_valid !== 1'b0 || wr_ready !== 1'b0) begin
      errs++;
      $display("FAIL reset_streams got %h/%b/%b want 00/0/0", rd_data, rd_valid, wr_ready);
    end
    vecs++;
    if (busy !== 1'b0 || cmd_ready !== 1'b1) begin
      errs++;
      $display("FAIL reset_ctrl got busy=%b rdy=%b want 0/1", busy, cmd_ready);
    end
    tick();
    rst = 1'b0;
    tick();
  endtask

  task automatic test_write_read();
    frame[0] = 6'h01;
    frame[1] = 6'h2A;
    frame[2] = 6'h15;
    frame[3] = 6'h3F;
    write_frame(-1);
    read_frame(-1);
  endtask

  task automatic test_back_to_back();
    read_frame(-1);
    read_frame(-1);
  endtask

  task automatic test_stall();
    frame[0] = 6'h3F;
    frame[1] = 6'h00;
    frame[2] = 6'h2A;
    frame[3] = 6'h15;
    write_frame(2);
    read_frame(1);
  endtask

  task automatic test_idle_quiet();
    int r0;
    r0 = rises;
    repeat (20) tick();
    vecs++;
    if (rises != r0 || sr_recirc !== 1'b1) begin
      errs++;
      $display("FAIL idle_quiet got %0d edges recirc=%b want 0/1", rises - r0, sr_recirc);
    end
  endtask

  task automatic test_reset_abort();
    int n;
    exp_recirc = 1'b0;
    issue(1'b0);
    for (int k = 0; k < 3; k++) begin
      wait_wr_ready();
      wr_data = 6'h07 + 6'(k);
      wr_valid = 1'b1;
      tick();
      wr_valid = 1'b0;
    end
    n = 0;
    while (!sr_clk && n < 50) begin
      tick();
      n++;
    end
    vecs++;
    if (sr_clk !== 1'b1) begin
      errs++;
      $display("FAIL abort_rise_wait got %b want 1", sr_clk);
    end
    #2;
    rst = 1'b1;
    #1;
    vecs++;
    if (sr_clk !== 1'b0 || busy !== 1'b0 || cmd_ready !== 1'b1 || sr_recirc !== 1'b1) begin
      errs++;
      $display("FAIL abort_reset got clk=%b busy=%b rdy=%b rc=%b want 0/0/1/1",
               sr_clk, busy, cmd_ready, sr_recirc);
    end
    tick();
    rst = 1'b0;
    exp_recirc = 1'b1;
    tick();
    frame[0] = 6'h2C;
    frame[1] = 6'h13;
    frame[2] = 6'h0B;
    frame[3] = 6'h34;
    write_frame(-1);
    read_frame(-1);
  endtask

  initial begin
    repeat (3) tick();
    test_reset();
    test_write_read();
    test_back_to_back();
    test_idle_quiet();
    test_stall();
    test_reset_abort();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog got timeout want completion");
    $fatal(1, "watchdog");
  end

endmodule
